// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and default widths for the APB master.
// The state encoding matches the memory-backed APB slave.
package apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles spent with Pready low.
// Flags expiry on the cycle whose edge would reach TIMEOUT_CYCLES.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_access,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Held at zero outside ACCESS so each transfer starts from a clean count.
    always_ff @(posedge clk) begin
        if (rst || !in_access) begin
            cnt <= '0;
        end else if (!ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = in_access && !ready && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready command port to APB requester, one transfer at a time.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic              Pready,
    input  logic              Pslverr,
    input  logic [DATA_W-1:0] Prdata
);

    apb_state_t state;
    apb_state_t next_state;

    logic req_fire;
    logic in_access;
    logic timeout_hit;
    logic access_end;

    assign req_ready  = (state == IDLE) && !rsp_valid && !Prst;
    assign req_fire   = req_valid && req_ready;
    assign in_access  = (state == ACCESS);
    assign access_end = Pready || timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (Pclk),
        .rst      (Prst),
        .in_access(in_access),
        .ready    (Pready),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; reset drops any transfer in flight.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and APB phase strobes.
    always_comb begin
        next_state = state;
        Pselx      = 1'b0;
        Penable    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                Pselx      = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                Pselx   = 1'b1;
                Penable = 1'b1;
                if (access_end) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture; held through SETUP/ACCESS and kept in IDLE.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            Pwrite <= 1'b0;
            Paddr  <= '0;
            Pwdata <= '0;
        end else if (req_fire) begin
            Pwrite <= req_write;
            Paddr  <= req_addr;
            Pwdata <= req_wdata;
        end
    end

    // Response register; Pready wins over a timeout on the same edge.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (in_access && Pready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= Pslverr;
            rsp_rdata <= Pwrite ? '0 : Prdata;
        end else if (in_access && timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table vectors, random traffic vs. a memory reference model,
// and hand sequences for reset-in-ACCESS and the optional timeout.
module tb_apb_master;

    logic        Pclk = 1'b0;
    logic        Prst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pready;
    logic        Pslverr;
    logic [31:0] Prdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    always #5 Pclk = ~Pclk;

    apb_master dut (
        .Pclk     (Pclk),
        .Prst     (Prst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr),
        .Prdata   (Prdata)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a, input bit slave);
        if (slave) return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One full command: accept, SETUP, ACCESS with waits, response, hold.
    task automatic run_txn(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic err, input int hold,
                           input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] pa;
        logic [31:0] pd;
        logic [31:0] r0;
        logic        e0;
        pa = '0;
        pd = '0;
        @(negedge Pclk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        Pready    = 1'b1;
        Pslverr   = 1'b1;
        Prdata    = 32'hBAD0_0001;
        chk("req_ready_idle", req_ready, 1);
        @(negedge Pclk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk("setup_strobes", {Pselx, Penable}, 2'b10);
        chk("setup_paddr", Paddr, addr);
        chk("setup_pwdata", Pwdata, wdata);
        chk("setup_pwrite", Pwrite, wr);
        chk("setup_req_ready", req_ready, 0);
        Prdata = 32'hBAD0_0002;
        @(negedge Pclk);
        for (int w = 0; w <= waits; w++) begin
            chk("access_strobes", {Pselx, Penable}, 2'b11);
            chk("access_paddr", Paddr, addr);
            chk("access_pwdata", Pwdata, wdata);
            chk("access_pwrite", Pwrite, wr);
            chk("access_no_rsp", rsp_valid, 0);
            pa = Paddr;
            pd = Pwdata;
            if (w == waits) begin
                Pready  = 1'b1;
                Pslverr = err;
                Prdata  = Pwrite ? $urandom : rd_mem(Paddr, 1'b1);
            end else begin
                Pready  = 1'b0;
                Pslverr = 1'b1;
                Prdata  = $urandom;
            end
            @(negedge Pclk);
        end
        if (wr && !err) slave_mem[pa] = pd;
        Pready  = 1'b0;
        Pslverr = 1'b0;
        chk("rsp_strobes", {Pselx, Penable}, 2'b00);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_req_ready", req_ready, 0);
        chk("idle_paddr_kept", Paddr, addr);
        r0 = rsp_rdata;
        e0 = rsp_err;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge Pclk);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_psel", Pselx, 0);
            chk("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, e0, r0});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge Pclk);
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
        chk("post_psel", Pselx, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bus"}, {Pselx, Penable, Pwrite}, 3'b000);
        chk({tag, "_paddr"}, Paddr, 0);
        chk({tag, "_pwdata"}, Pwdata, 0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 2'b00);
        chk({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        logic        wr;
        logic        er;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er_data;

        vecs[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0, 0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h04, 32'h0, 0, 1'b0, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h08, 32'h12345678, 3, 1'b0, 1, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h08, 32'h0, 3, 1'b0, 0, 32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 32'h04, 32'h0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b1};
        vecs[5] = '{1'b1, 32'h0C, 32'hCAFEF00D, 1, 1'b1, 2, 32'h0, 1'b1};

        Prst      = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'hFFFF_FFFF;
        rsp_ready = 1'b0;
        Pready    = 1'b1;
        Pslverr   = 1'b1;
        Prdata    = 32'hFFFF_FFFF;
        repeat (2) @(negedge Pclk);
        chk("reset_req_ready", req_ready, 0);
        check_all_zero("reset");
        Prst      = 1'b0;
        req_valid = 1'b0;
        Pready    = 1'b0;
        Pslverr   = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    vecs[i].err, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err);
            if (vecs[i].wr && !vecs[i].err) ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // Reset pulsed while the slave is stalling in ACCESS.
        @(negedge Pclk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55AA55AA;
        @(negedge Pclk);
        req_valid = 1'b0;
        @(negedge Pclk);
        chk("pre_reset_access", {Pselx, Penable}, 2'b11);
        Prst = 1'b1;
        #1;
        chk("mid_reset_req_ready", req_ready, 0);
        @(negedge Pclk);
        check_all_zero("mid_reset");
        Prst = 1'b0;
        @(negedge Pclk);
        chk("after_reset_rsp", rsp_valid, 0);
        chk("after_reset_req_ready", req_ready, 1);
        run_txn(1'b0, 32'h04, 32'h0, 0, 1'b0, 0, 32'hDEADBEEF, 1'b0);

        // Random traffic against the memory reference model.
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 7)) << 2;
            d  = $urandom;
            er = ($urandom_range(0, 7) == 0);
            er_data = wr ? 32'h0 : rd_mem(a, 1'b0);
            run_txn(wr, a, d, $urandom_range(0, 3), er, $urandom_range(0, 2),
                    er_data, er);
            if (wr && !er) ref_mem[a] = d;
        end

`ifdef APB_MASTER_TIMEOUT_EN
        // Slave never answers: abort after 16 ACCESS cycles.
        @(negedge Pclk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h04;
        @(negedge Pclk);
        req_valid = 1'b0;
        Pready    = 1'b0;
        @(negedge Pclk);
        for (int w = 0; w < 16; w++) begin
            chk("to_access", {Pselx, Penable, rsp_valid}, 3'b110);
            Prdata = $urandom;
            @(negedge Pclk);
        end
        chk("to_rsp", {Pselx, Penable, rsp_valid, rsp_err}, 4'b0011);
        chk("to_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge Pclk);
        rsp_ready = 1'b0;
        // Pready in the 16th ACCESS cycle completes normally.
        run_txn(1'b0, 32'h04, 32'h0, 15, 1'b0, 0, rd_mem(32'h04, 1'b0), 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
